pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RV32I core. It drives the bubble (hold) and flush (clear) inputs of the IF/ID/EX/MEM/WB segment registers and selects EX operand forwarding. It also sequences a multi-cycle CSR drain and counts stall and flush events for debug. It sits beside the datapath and has no datapath storage of its own.

Parameters:
CSR_DRAIN_CYC, 2, extra hold cycles after a CSR write reaches EX (1..7)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
reg1_src_ID  in  5  rs1 address of instruction in ID
reg2_src_ID  in  5  rs2 address of instruction in ID
reg1_used_ID  in  1  ID instruction reads rs1
reg2_used_ID  in  1  ID instruction reads rs2
reg1_src_EX  in  5  rs1 address in EX
reg2_src_EX  in  5  rs2 address in EX
reg_dest_EX  in  5  rd address in EX
load_EX  in  1  EX instruction is a load
csr_write_EX  in  1  EX instruction writes a CSR
reg_dest_MEM  in  5  rd address in MEM
reg_write_en_MEM  in  1  MEM instruction writes rd
reg_dest_WB  in  5  rd address in WB
reg_write_en_WB  in  1  WB instruction writes rd
br_EX  in  1  taken branch resolved in EX
jalr_EX  in  1  jalr in EX
jal_ID  in  1  jal decoded in ID
miss  in  1  data cache miss pending
bubbleF, flushF, bubbleD, flushD, bubbleE, flushE, bubbleM, flushM, bubbleW, flushW  out  1 each  segment register controls
op1_sel  out  2  EX operand 1 source: 0 regfile, 1 MEM result, 2 WB result
op2_sel  out  2  same for operand 2
stall_cnt  out  CNT_W  cycles with bubbleF=1
flush_cnt  out  CNT_W  cycles with flushD=1 caused by br_EX/jalr_EX

Behaviour:
- State register: RUN or DRAIN, plus a 3-bit drain counter. Reset: RUN, counter 0, stall_cnt=0, flush_cnt=0.
- All bubble/flush outputs are combinational from the current state and inputs. Exactly one priority level applies per cycle. Outputs not listed for a level are 0.
  1. rst=1: all five flush=1.
  2. miss=1: all five bubble=1. State and drain counter are frozen.
  3. br_EX or jalr_EX: flushD=1, flushE=1.
  4. State DRAIN: bubbleF=1, bubbleD=1, flushE=1.
  5. csr_write_EX=1 in RUN: bubbleF=1, bubbleD=1, flushE=1.
     - Next state is DRAIN with counter=CSR_DRAIN_CYC.
  6. Load-use hazard: bubbleF=1, bubbleD=1, flushE=1.
     - Condition: load_EX=1, reg_dest_EX!=0, and either (reg1_used_ID and reg1_src_ID==reg_dest_EX) or (reg2_used_ID and reg2_src_ID==reg_dest_EX).
  7. jal_ID: flushD=1.
- DRAIN state: the counter decrements on each cycle where miss=0. When the counter reaches 1 and decrements, the next state is RUN. A CSR write therefore stalls exactly 1+CSR_DRAIN_CYC non-miss cycles.
- Forwarding for op1_sel / op2_sel, evaluated independently per operand against reg1_src_EX / reg2_src_EX:
  - Select 1 if reg_write_en_MEM=1, reg_dest_MEM==src, and src!=0.
  - Else select 2 if reg_write_en_WB=1, reg_dest_WB==src, and src!=0.
  - Else select 0. MEM has priority over WB.
  - Forwarding outputs are 0 while rst=1.
- Counters:
  - stall_cnt increments on every non-reset cycle where bubbleF=1.
  - flush_cnt increments on every non-reset cycle where level 3 applies.
  - Both wrap to 0 after all-ones. No saturation.
- Reset mid-DRAIN or mid-miss: returns to RUN on the next edge and clears the counters.

Test Plan:
- Reset: rst=1 for 2 cycles -> all flush=1, stall_cnt=0, flush_cnt=0. First cycle after release -> all outputs 0.
- Load-use: load_EX=1, reg_dest_EX=5, reg1_used_ID=1, reg1_src_ID=5 -> bubbleF=bubbleD=flushE=1 for 1 cycle, stall_cnt+1. Repeat with reg_dest_EX=0 -> no stall.
- Forwarding: reg1_src_EX=3, MEM rd=3 wen=1, WB rd=3 wen=1 -> op1_sel=1. Drop MEM wen -> op1_sel=2. reg1_src_EX=0 -> op1_sel=0.
- CSR drain: csr_write_EX=1 pulse with CSR_DRAIN_CYC=2 -> 3 consecutive cycles of bubbleF/bubbleD/flushE. Insert miss=1 for 4 cycles in the middle -> all bubbles for those 4 cycles, drain resumes, total stall_cnt=7.
- Branch vs load-use: br_EX=1 together with a load-use match -> flushD=flushE=1, bubbleF=0, flush_cnt+1, stall_cnt unchanged.
- Counter wrap: CNT_W=4, 16 load-use stalls -> stall_cnt returns to 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard controller for a 5-stage RV32I core. It drives the bubble
// (hold) and flush (clear) controls of the IF/ID/EX/MEM/WB segment
// registers, selects EX operand forwarding, sequences a multi-cycle drain
// after a CSR write, and counts stall and redirect-flush events for debug.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   reg*_src_ID, reg*_used_ID  source registers of the instruction in ID
//   reg*_src_EX, reg_dest_EX   register addresses of the instruction in EX
//   load_EX, csr_write_EX      EX instruction kind
//   reg_dest_MEM/WB, reg_write_en_MEM/WB  writers in MEM and WB
//   br_EX, jalr_EX, jal_ID     control-flow redirects
//   miss                       data cache miss pending
//   bubble*/flush*             segment register hold/clear controls
//   op1_sel, op2_sel           EX operand source (0 regfile, 1 MEM, 2 WB)
//   stall_cnt, flush_cnt       wrapping debug event counters
module pipeline_hazard_ctrl #(
    parameter int CSR_DRAIN_CYC = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       reg1_src_ID,
    input  logic [4:0]       reg2_src_ID,
    input  logic             reg1_used_ID,
    input  logic             reg2_used_ID,
    input  logic [4:0]       reg1_src_EX,
    input  logic [4:0]       reg2_src_EX,
    input  logic [4:0]       reg_dest_EX,
    input  logic             load_EX,
    input  logic             csr_write_EX,
    input  logic [4:0]       reg_dest_MEM,
    input  logic             reg_write_en_MEM,
    input  logic [4:0]       reg_dest_WB,
    input  logic             reg_write_en_WB,
    input  logic             br_EX,
    input  logic             jalr_EX,
    input  logic             jal_ID,
    input  logic             miss,
    output logic             bubbleF,
    output logic             flushF,
    output logic             bubbleD,
    output logic             flushD,
    output logic             bubbleE,
    output logic             flushE,
    output logic             bubbleM,
    output logic             flushM,
    output logic             bubbleW,
    output logic             flushW,
    output logic [1:0]       op1_sel,
    output logic [1:0]       op2_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] drain_cnt, drain_cnt_nxt;
    logic       load_use;
    logic       redirect;
    logic       redirect_evt;

    assign redirect = br_EX | jalr_EX;

    // A load in EX whose result the ID instruction needs cannot be forwarded
    // in time; x0 never creates a dependency.
    assign load_use = load_EX && (reg_dest_EX != 5'd0) &&
                      ((reg1_used_ID && (reg1_src_ID == reg_dest_EX)) ||
                       (reg2_used_ID && (reg2_src_ID == reg_dest_EX)));

    // Priority-ordered segment controls and next-state logic.
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        bubbleF       = 1'b0;
        bubbleD       = 1'b0;
        bubbleE       = 1'b0;
        bubbleM       = 1'b0;
        bubbleW       = 1'b0;
        flushF        = 1'b0;
        flushD        = 1'b0;
        flushE        = 1'b0;
        flushM        = 1'b0;
        flushW        = 1'b0;
        redirect_evt  = 1'b0;
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;

        if (rst) begin
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else if (miss) begin
            // Whole pipe holds; the drain sequence is frozen as well.
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            bubbleE = 1'b1;
            bubbleM = 1'b1;
            bubbleW = 1'b1;
        end else if (redirect) begin
            flushD       = 1'b1;
            flushE       = 1'b1;
            redirect_evt = 1'b1;
        end else if (state == DRAIN) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
        end else if (csr_write_EX) begin
            bubbleF       = 1'b1;
            bubbleD       = 1'b1;
            flushE        = 1'b1;
            state_nxt     = DRAIN;
            drain_cnt_nxt = 3'(CSR_DRAIN_CYC);
        end else if (load_use) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
        end else if (jal_ID) begin
            flushD = 1'b1;
        end

        // The drain count advances on every non-miss cycle in DRAIN,
        // including cycles where a redirect owns the controls.
        if (!rst && !miss && (state == DRAIN)) begin
            drain_cnt_nxt = drain_cnt - 3'd1;
            if (drain_cnt <= 3'd1) begin
                state_nxt = RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (bubbleF) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect_evt) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] dest_mem,
        input logic       wen_mem,
        input logic [4:0] dest_wb,
        input logic       wen_wb
    );
        if (wen_mem && (dest_mem == src) && (src != 5'd0)) begin
            return 2'd1;
        end else if (wen_wb && (dest_wb == src) && (src != 5'd0)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    always_comb begin
        op1_sel = 2'd0;
        op2_sel = 2'd0;
        if (!rst) begin
            op1_sel = fwd_sel(reg1_src_EX, reg_dest_MEM, reg_write_en_MEM,
                              reg_dest_WB, reg_write_en_WB);
            op2_sel = fwd_sel(reg2_src_EX, reg_dest_MEM, reg_write_en_MEM,
                              reg_dest_WB, reg_write_en_WB);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by randomized traffic, all compared against a behavioural model that
// tracks "stall cycles still owed to a CSR drain" and the two event counts.
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN_CYC = 2;
    localparam int CW        = 4;
    localparam int CNT_MOD   = 1 << CW;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    reg1_src_ID, reg2_src_ID;
    logic          reg1_used_ID, reg2_used_ID;
    logic [4:0]    reg1_src_EX, reg2_src_EX, reg_dest_EX;
    logic          load_EX, csr_write_EX;
    logic [4:0]    reg_dest_MEM, reg_dest_WB;
    logic          reg_write_en_MEM, reg_write_en_WB;
    logic          br_EX, jalr_EX, jal_ID, miss;
    logic          bubbleF, flushF, bubbleD, flushD, bubbleE, flushE;
    logic          bubbleM, flushM, bubbleW, flushW;
    logic [1:0]    op1_sel, op2_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .CSR_DRAIN_CYC(DRAIN_CYC),
        .CNT_W        (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .reg1_src_ID     (reg1_src_ID),
        .reg2_src_ID     (reg2_src_ID),
        .reg1_used_ID    (reg1_used_ID),
        .reg2_used_ID    (reg2_used_ID),
        .reg1_src_EX     (reg1_src_EX),
        .reg2_src_EX     (reg2_src_EX),
        .reg_dest_EX     (reg_dest_EX),
        .load_EX         (load_EX),
        .csr_write_EX    (csr_write_EX),
        .reg_dest_MEM    (reg_dest_MEM),
        .reg_write_en_MEM(reg_write_en_MEM),
        .reg_dest_WB     (reg_dest_WB),
        .reg_write_en_WB (reg_write_en_WB),
        .br_EX           (br_EX),
        .jalr_EX         (jalr_EX),
        .jal_ID          (jal_ID),
        .miss            (miss),
        .bubbleF         (bubbleF),
        .flushF          (flushF),
        .bubbleD         (bubbleD),
        .flushD          (flushD),
        .bubbleE         (bubbleE),
        .flushE          (flushE),
        .bubbleM         (bubbleM),
        .flushM          (flushM),
        .bubbleW         (bubbleW),
        .flushW          (flushW),
        .op1_sel         (op1_sel),
        .op2_sel         (op2_sel),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_drain_left = 0;   // drain stall cycles still owed after a CSR write
    int m_stall      = 0;
    int m_flush      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (reg_write_en_MEM && reg_dest_MEM == src) return 2'd1;
        if (reg_write_en_WB && reg_dest_WB == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic idle();
        rst = 1'b0;
        reg1_src_ID = '0; reg2_src_ID = '0; reg1_used_ID = 1'b0; reg2_used_ID = 1'b0;
        reg1_src_EX = '0; reg2_src_EX = '0; reg_dest_EX = '0;
        load_EX = 1'b0; csr_write_EX = 1'b0;
        reg_dest_MEM = '0; reg_write_en_MEM = 1'b0;
        reg_dest_WB = '0; reg_write_en_WB = 1'b0;
        br_EX = 1'b0; jalr_EX = 1'b0; jal_ID = 1'b0; miss = 1'b0;
    endtask

    // Inputs are applied at the falling edge; this checks the cycle's
    // outputs, advances the model across the next rising edge, and returns
    // at the following falling edge.
    task automatic tick(input string tag);
        int         lvl;
        logic       lu;
        logic [9:0] exp_ctrl;   // {bubble F,D,E,M,W, flush F,D,E,M,W}
        logic [9:0] obs_ctrl;
        #1;
        lu = load_EX && (reg_dest_EX != 0) &&
             ((reg1_used_ID && reg1_src_ID == reg_dest_EX) ||
              (reg2_used_ID && reg2_src_ID == reg_dest_EX));
        if (rst)                       lvl = 1;
        else if (miss)                 lvl = 2;
        else if (br_EX || jalr_EX)     lvl = 3;
        else if (m_drain_left > 0)     lvl = 4;
        else if (csr_write_EX)         lvl = 5;
        else if (lu)                   lvl = 6;
        else if (jal_ID)               lvl = 7;
        else                           lvl = 0;
        case (lvl)
            1:       exp_ctrl = 10'b00000_11111;
            2:       exp_ctrl = 10'b11111_00000;
            3:       exp_ctrl = 10'b00000_01100;
            4, 5, 6: exp_ctrl = 10'b11000_00100;
            7:       exp_ctrl = 10'b00000_01000;
            default: exp_ctrl = 10'b00000_00000;
        endcase
        obs_ctrl = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
                    flushF, flushD, flushE, flushM, flushW};
        check({tag, "/ctrl"}, 32'(obs_ctrl), 32'(exp_ctrl));
        check({tag, "/op1"}, 32'(op1_sel), rst ? 32'd0 : 32'(model_fwd(reg1_src_EX)));
        check({tag, "/op2"}, 32'(op2_sel), rst ? 32'd0 : 32'(model_fwd(reg2_src_EX)));
        check({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        check({tag, "/flush_cnt"}, 32'(flush_cnt), 32'(m_flush));

        if (rst) begin
            m_drain_left = 0;
            m_stall      = 0;
            m_flush      = 0;
        end else begin
            if (exp_ctrl[9]) m_stall = (m_stall + 1) % CNT_MOD;
            if (lvl == 3)    m_flush = (m_flush + 1) % CNT_MOD;
            if (!miss) begin
                if (m_drain_left > 0) m_drain_left--;
                else if (lvl == 5)    m_drain_left = DRAIN_CYC;
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        idle();
        rst = 1'b1;
        tick("rst_pulse");
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset: flushes asserted, counters cleared; then everything quiet.
        tick("reset0");
        tick("reset1");
        check("reset_stall_zero", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        tick("after_reset");

        // Load-use stall on rs1, then the same pattern targeting x0.
        load_EX = 1'b1; reg_dest_EX = 5'd5; reg1_used_ID = 1'b1; reg1_src_ID = 5'd5;
        tick("load_use");
        check("load_use_stall_cnt", 32'(stall_cnt), 32'd1);
        reg_dest_EX = 5'd0; reg1_src_ID = 5'd0;
        tick("load_use_x0");
        check("load_use_x0_stall_cnt", 32'(stall_cnt), 32'd1);
        idle();

        // Forwarding priority and x0.
        reg1_src_EX = 5'd3; reg_dest_MEM = 5'd3; reg_write_en_MEM = 1'b1;
        reg_dest_WB = 5'd3; reg_write_en_WB = 1'b1;
        #1 check("fwd_mem", 32'(op1_sel), 32'd1);
        tick("fwd_mem");
        reg_write_en_MEM = 1'b0;
        #1 check("fwd_wb", 32'(op1_sel), 32'd2);
        tick("fwd_wb");
        reg1_src_EX = 5'd0; reg_dest_WB = 5'd0;
        tick("fwd_x0");
        idle();

        // CSR drain interrupted by a 4-cycle miss: 7 stall cycles in total.
        reset_pulse();
        csr_write_EX = 1'b1;
        tick("csr_start");
        csr_write_EX = 1'b0;
        tick("csr_drain_a");
        miss = 1'b1;
        repeat (4) tick("csr_miss");
        miss = 1'b0;
        tick("csr_drain_b");
        check("csr_total_stall", 32'(stall_cnt), 32'd7);
        tick("csr_done");

        // Branch takes priority over a simultaneous load-use hazard.
        reset_pulse();
        br_EX = 1'b1; load_EX = 1'b1; reg_dest_EX = 5'd7;
        reg2_used_ID = 1'b1; reg2_src_ID = 5'd7;
        tick("br_vs_lu");
        check("br_vs_lu_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_vs_lu_stall_cnt", 32'(stall_cnt), 32'd0);
        idle();

        // Counter wrap: 16 stalls on a 4-bit counter land back on 0.
        reset_pulse();
        load_EX = 1'b1; reg_dest_EX = 5'd9; reg2_used_ID = 1'b1; reg2_src_ID = 5'd9;
        repeat (16) tick("wrap");
        idle();
        check("wrap_stall_zero", 32'(stall_cnt), 32'd0);
        tick("wrap_done");

        // Randomized traffic on a small register range so matches are common.
        for (int i = 0; i < 1500; i++) begin
            rst              = ($urandom_range(0, 63) == 0);
            miss             = ($urandom_range(0, 9) == 0);
            br_EX            = ($urandom_range(0, 11) == 0);
            jalr_EX          = ($urandom_range(0, 15) == 0);
            jal_ID           = ($urandom_range(0, 7) == 0);
            csr_write_EX     = ($urandom_range(0, 9) == 0);
            load_EX          = ($urandom_range(0, 2) == 0);
            reg1_src_ID      = 5'($urandom_range(0, 3));
            reg2_src_ID      = 5'($urandom_range(0, 3));
            reg1_used_ID     = 1'($urandom_range(0, 1));
            reg2_used_ID     = 1'($urandom_range(0, 1));
            reg1_src_EX      = 5'($urandom_range(0, 3));
            reg2_src_EX      = 5'($urandom_range(0, 3));
            reg_dest_EX      = 5'($urandom_range(0, 3));
            reg_dest_MEM     = 5'($urandom_range(0, 3));
            reg_dest_WB      = 5'($urandom_range(0, 3));
            reg_write_en_MEM = 1'($urandom_range(0, 1));
            reg_write_en_WB  = 1'($urandom_range(0, 1));
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
